// File: rtl/bus_timer_pkg.sv
// Shared constants for bus_timer: register offsets and CTRL/STAT bit positions.
package bus_timer_pkg;

  localparam int unsigned TMR_CTRL   = 0;
  localparam int unsigned TMR_PRESC  = 1;
  localparam int unsigned TMR_RELOAD = 2;
  localparam int unsigned TMR_COUNT  = 3;
  localparam int unsigned TMR_STAT   = 4;
  localparam int unsigned TMR_CAP    = 5;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_W    = 3;

  localparam int STAT_UF = 0;
  localparam int STAT_CF = 1;

endpackage

// File: rtl/bus_timer_if.sv
// CPU-bus view of bus_timer: the CPU side drives the master modport, the timer the slave.
interface bus_timer_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 4
);
  logic                 cs;
  logic [ADDR_SIZE-1:0] addr;
  logic [WIDTH-1:0]     din;
  logic                 wen;
  logic [WIDTH-1:0]     dout;
  logic                 irq;
  logic                 cap_in;

  modport master (output cs, addr, din, wen, cap_in, input dout, irq);
  modport slave  (input cs, addr, din, wen, cap_in, output dout, irq);
endinterface

// File: rtl/bus_timer_presc.sv
// Prescaler for bus_timer: emits a one-clk tick every (div+1) clks while run is high.
module bus_timer_presc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             restart,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);
  logic [WIDTH-1:0] r_psc_cnt;

  assign tick = run & (r_psc_cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psc_cnt <= '0;
    end else if (!run || restart || tick) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      r_psc_cnt <= '0;
    end else begin
      r_psc_cnt <= r_psc_cnt + WIDTH'(1);
    end
  end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counter timer with one-shot/auto-reload and irq on underflow.
// Optional capture unit (CAP register, CF flag) is built only when BUS_TIMER_CAPTURE_EN is defined.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);
  logic [CTRL_W-1:0] r_ctrl;
  logic [WIDTH-1:0]  r_presc, r_reload, r_count;
  logic              r_uf;
  logic [WIDTH-1:0]  w_rdata, w_cap;
  logic              w_cf, w_tick, w_uf_evt, w_restart;
  logic              w_wr, w_wr_ctrl, w_wr_presc, w_wr_reload, w_wr_count, w_wr_stat;

  assign w_wr        = bus.cs & bus.wen;
  assign w_wr_ctrl   = w_wr & (bus.addr == ADDR_SIZE'(TMR_CTRL));
  assign w_wr_presc  = w_wr & (bus.addr == ADDR_SIZE'(TMR_PRESC));
  assign w_wr_reload = w_wr & (bus.addr == ADDR_SIZE'(TMR_RELOAD));
  assign w_wr_count  = w_wr & (bus.addr == ADDR_SIZE'(TMR_COUNT));
  assign w_wr_stat   = w_wr & (bus.addr == ADDR_SIZE'(TMR_STAT));
  assign w_restart   = w_wr_ctrl & bus.din[CTRL_RUN] & ~r_ctrl[CTRL_RUN];

  bus_timer_presc #(.WIDTH(WIDTH)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .run     (r_ctrl[CTRL_RUN]),
    .restart (w_restart),
    .div     (r_presc),
    .tick    (w_tick)
  );

  assign w_uf_evt = w_tick & (r_count == '0);

  // CPU writes are applied last so they override the counter's own updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_presc  <= '0;
      r_reload <= '0;
      r_count  <= '0;
      r_uf     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= bus.din[CTRL_W-1:0];
      end else if (w_uf_evt && !r_ctrl[CTRL_AUTO]) begin
        r_ctrl[CTRL_RUN] <= 1'b0;
      end
      if (w_wr_presc)  r_presc  <= bus.din;
      if (w_wr_reload) r_reload <= bus.din;
      if (w_wr_count) begin
        r_count <= bus.din;
      end else if (w_tick) begin
        if (r_count != '0)          r_count <= r_count - WIDTH'(1);
        else if (r_ctrl[CTRL_AUTO]) r_count <= r_reload;
      end
      r_uf <= (r_uf & ~(w_wr_stat & bus.din[STAT_UF])) | w_uf_evt;
    end
  end

`ifdef BUS_TIMER_CAPTURE_EN
  logic             r_cap_prev, r_cf;
  logic [WIDTH-1:0] r_cap;
  logic             w_cap_evt;

  assign w_cap_evt = bus.cap_in & ~r_cap_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_prev <= 1'b0;
      r_cf       <= 1'b0;
      r_cap      <= '0;
    end else begin
      r_cap_prev <= bus.cap_in;
      if (w_cap_evt) r_cap <= r_count;
      r_cf <= (r_cf & ~(w_wr_stat & bus.din[STAT_CF])) | w_cap_evt;
    end
  end

  assign w_cf  = r_cf;
  assign w_cap = r_cap;
`else
  assign w_cf  = 1'b0;
  assign w_cap = '0;
`endif

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_rdata = '0;
    if (bus.cs) begin
      case (bus.addr)
        ADDR_SIZE'(TMR_CTRL):   w_rdata[CTRL_W-1:0] = r_ctrl;
        ADDR_SIZE'(TMR_PRESC):  w_rdata = r_presc;
        ADDR_SIZE'(TMR_RELOAD): w_rdata = r_reload;
        ADDR_SIZE'(TMR_COUNT):  w_rdata = r_count;
        ADDR_SIZE'(TMR_STAT): begin
          w_rdata[STAT_UF] = r_uf;
          w_rdata[STAT_CF] = w_cf;
        end
        ADDR_SIZE'(TMR_CAP):    w_rdata = w_cap;
        default:                w_rdata = '0;
      endcase
    end
  end

  assign bus.dout = w_rdata;
  assign bus.irq  = r_ctrl[CTRL_IE] & (r_uf | w_cf);
endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: a per-cycle reference model plus directed literal checks.
module tb_bus_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_timer_if #(.WIDTH(32), .ADDR_SIZE(4)) bus ();

  bus_timer #(.WIDTH(32), .ADDR_SIZE(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: what each register must hold after the latest edge.
  logic        m_run = 0, m_auto = 0, m_ie = 0, m_uf = 0, m_cf = 0, m_cap_prev = 0;
  logic [31:0] m_presc = 0, m_reload = 0, m_count = 0, m_cap = 0, m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic c, input logic [3:0] a);
    if (!c) return 32'h0;
    case (a)
      4'd0:    return {29'h0, m_ie, m_auto, m_run};
      4'd1:    return m_presc;
      4'd2:    return m_reload;
      4'd3:    return m_count;
      4'd4:    return {30'h0, m_cf, m_uf};
      4'd5:    return m_cap;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    {m_run, m_auto, m_ie, m_uf, m_cf, m_cap_prev} = '0;
    {m_presc, m_reload, m_count, m_cap, m_left} = '0;
  endtask

  // Ticks arrive every (PRESC+1) running cycles, counted down in m_left.
  task automatic model_edge();
    logic        wr, tick, uf_evt, run_old, cap_set;
    logic [31:0] cnt_old, presc_old;
    wr        = bus.cs && bus.wen;
    run_old   = m_run;
    cnt_old   = m_count;
    presc_old = m_presc;
    tick      = m_run && (m_left == 0);
    uf_evt    = tick && (m_count == 0);
    cap_set   = 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
    cap_set    = bus.cap_in && !m_cap_prev;
    m_cap_prev = bus.cap_in;
`endif
    if (wr && bus.addr == 4'd4) begin
      if (bus.din[0]) m_uf = 1'b0;
      if (bus.din[1]) m_cf = 1'b0;
    end
    if (uf_evt) m_uf = 1'b1;
    if (cap_set) begin
      m_cf  = 1'b1;
      m_cap = cnt_old;
    end
    if (tick) m_count = (cnt_old != 0) ? cnt_old - 1 : (m_auto ? m_reload : cnt_old);
    if (uf_evt && !m_auto) m_run = 1'b0;
    if (wr) begin
      case (bus.addr)
        4'd0: {m_ie, m_auto, m_run} = bus.din[2:0];
        4'd1: m_presc  = bus.din;
        4'd2: m_reload = bus.din;
        4'd3: m_count  = bus.din;
        default: ;
      endcase
    end
    if (!run_old)  m_left = m_presc;
    else if (tick) m_left = presc_old;
    else           m_left = m_left - 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_dout", bus.dout, model_read(bus.cs, bus.addr));
      check("cyc_irq", {31'h0, bus.irq}, {31'h0, m_ie & (m_uf | m_cf)});
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.wen = 1'b1; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.cs = 1'b1; bus.wen = 1'b0; bus.addr = a;
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic irq_is(input string name, input logic exp);
    check(name, {31'h0, bus.irq}, {31'h0, exp});
  endtask

  initial begin
    logic [31:0] exp_cap, exp_stat;
    logic        exp_irq;
    bus.cs = 0; bus.wen = 0; bus.addr = 0; bus.din = 0; bus.cap_in = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) rd("rst_read", 4'(i), 32'h0);
    irq_is("rst_irq", 1'b0);
    bus.cs = 1'b0; #1;
    check("cs0_dout", bus.dout, 32'h0);

    // One-shot countdown, IE off
    wr(4'd1, 0); wr(4'd3, 3); wr(4'd0, 1);
    rd("os_count3", 4'd3, 3);
    step(1); rd("os_count2", 4'd3, 2);
    step(1); rd("os_count1", 4'd3, 1);
    step(1); rd("os_count0", 4'd3, 0);
    step(1);
    rd("os_stat", 4'd4, 1); rd("os_ctrl", 4'd0, 0); rd("os_hold0", 4'd3, 0);
    irq_is("os_irq", 1'b0);

    // Prescaled auto-reload with irq
    wr(4'd4, 1);
    wr(4'd1, 2); wr(4'd2, 5); wr(4'd3, 1); wr(4'd0, 7);
    step(2); rd("ar_wait", 4'd3, 1);
    step(1); rd("ar_dec", 4'd3, 0);
    step(2); rd("ar_zero", 4'd3, 0); irq_is("ar_noirq", 1'b0);
    step(1); rd("ar_reload", 4'd3, 5); rd("ar_uf", 4'd4, 1); irq_is("ar_irq", 1'b1);
    wr(4'd4, 1);
    irq_is("ar_irq_clr", 1'b0); rd("ar_uf_clr", 4'd4, 0); rd("ar_keep", 4'd3, 5);

    // Write collisions with PRESC=0
    wr(4'd0, 0); wr(4'd1, 0); wr(4'd2, 3); wr(4'd3, 10); wr(4'd0, 3);
    rd("col_start", 4'd3, 10);
    step(1); rd("col_dec", 4'd3, 9);
    wr(4'd3, 32'h100); rd("col_wrwin", 4'd3, 32'h100);
    step(1); rd("col_after", 4'd3, 32'hFF);
    wr(4'd3, 1); step(1); rd("col_at0", 4'd3, 0);
    wr(4'd4, 1);
    rd("col_setwin", 4'd4, 1); rd("col_rel", 4'd3, 3);

    // CTRL write coincident with one-shot stop
    wr(4'd0, 0); wr(4'd4, 1); wr(4'd3, 1); wr(4'd0, 1);
    step(1); rd("ctl_at0", 4'd3, 0);
    wr(4'd0, 1);
    rd("ctl_wrwin", 4'd0, 1); rd("ctl_uf", 4'd4, 1);
    step(1); rd("ctl_stop", 4'd0, 0);

    // Capture
    wr(4'd0, 0); wr(4'd4, 3); wr(4'd3, 32'h40); wr(4'd0, 5);
    step(2); rd("cap_pre", 4'd3, 32'h3E);
    bus.cap_in = 1'b1;
    step(1);
    bus.cap_in = 1'b0;
`ifdef BUS_TIMER_CAPTURE_EN
    exp_cap = 32'h3E; exp_stat = 32'h2; exp_irq = 1'b1;
`else
    exp_cap = 32'h0;  exp_stat = 32'h0; exp_irq = 1'b0;
`endif
    rd("cap_val", 4'd5, exp_cap); rd("cap_stat", 4'd4, exp_stat);
    irq_is("cap_irq", exp_irq); rd("cap_count", 4'd3, 32'h3D);

    // Reset mid-countdown
    wr(4'd0, 0); wr(4'd4, 3); wr(4'd3, 32'h20); wr(4'd0, 1);
    step(2); rd("mid_count", 4'd3, 32'h1E);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) rd("mid_rst_read", 4'(i), 32'h0);
    irq_is("mid_rst_irq", 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    step(3); rd("post_count", 4'd3, 0); rd("post_ctrl", 4'd0, 0);
    wr(4'd3, 5); step(3); rd("post_idle", 4'd3, 5);
    wr(4'd0, 1); step(1); rd("post_run", 4'd3, 4);

    bus.cs = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
